// File: rtl/mux8to1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mux8to1_pkg                                                 |
// | Desc   : Shared state encoding and defaults for the mux scan stage.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package mux8to1_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int DEFAULT_SEL_WIDTH = 3;

endpackage : mux8to1_pkg
`default_nettype wire

// File: rtl/mux8to1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mux8to1                                                     |
// | Desc   : Combinational 2**SEL_WIDTH-to-1 data selector.              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mux8to1
    import mux8to1_pkg::*;
#(
    parameter int SEL_WIDTH = DEFAULT_SEL_WIDTH
) (
    input  logic [(1<<SEL_WIDTH)-1:0] data_in,
    input  logic [SEL_WIDTH-1:0]      select,
    output logic                      data_out
);

    assign data_out = data_in[select];

endmodule : mux8to1
`default_nettype wire

// File: rtl/mux_settle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mux_settle_timer                                            |
// | Desc   : Loadable down-counter flagging the end of a SELECT settle.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mux_settle_timer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int CW         = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int C_LOAD_INT = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [CW-1:0] C_LOAD = CW'(C_LOAD_INT);

    logic [CW-1:0] r_count;

    // Loaded one short: the cycle spent in SAMPLE is the last settle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= C_LOAD;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (SETTLE_CYCLES == 0) || (r_count == '0);

endmodule : mux_settle_timer
`default_nettype wire

// File: rtl/mux8to1_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mux8to1_scan_ctrl                                           |
// | Desc   : Steps a mux SELECT, samples DATA_OUT into a parallel word.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mux8to1_scan_ctrl
    import mux8to1_pkg::*;
#(
    parameter int SEL_WIDTH     = DEFAULT_SEL_WIDTH,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mux_out,
    output logic [SEL_WIDTH-1:0]      select,
    output logic                      busy,
    output logic                      cap_valid,
    input  logic                      cap_ready,
    output logic [(1<<SEL_WIDTH)-1:0] capture
);

    localparam int N = 1 << SEL_WIDTH;
    localparam logic [SEL_WIDTH-1:0] C_SEL_LAST = '1;
    localparam state_t C_SCAN_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t         r_state;
    logic [N-1:0]   r_word;
    logic [N-1:0]   w_word_next;
    logic           w_scan_go;
    logic           w_load;
    logic           w_settle_done;

    assign w_scan_go = start && ((r_state == IDLE) || (r_state == HOLD && cap_ready));
    assign w_load    = w_scan_go || (r_state == SAMPLE && select != C_SEL_LAST);

    always_comb begin
        w_word_next         = r_word;
        w_word_next[select] = mux_out;
    end

    mux_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .done (w_settle_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            select    <= '0;
            r_word    <= '0;
            capture   <= '0;
            busy      <= 1'b0;
            cap_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    select <= '0;
                    if (start) begin
                        busy    <= 1'b1;
                        r_state <= C_SCAN_ENTRY;
                    end
                end
                SETTLE: begin
                    if (w_settle_done) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_word <= w_word_next;
                    // The last code publishes the word including the bit sampled now.
                    if (select == C_SEL_LAST) begin
                        capture   <= w_word_next;
                        cap_valid <= 1'b1;
                        busy      <= 1'b0;
                        select    <= '0;
                        r_state   <= HOLD;
                    end else begin
                        select  <= select + 1'b1;
                        r_state <= C_SCAN_ENTRY;
                    end
                end
                HOLD: begin
                    if (cap_ready) begin
                        cap_valid <= 1'b0;
                        if (start) begin
                            busy    <= 1'b1;
                            select  <= '0;
                            r_state <= C_SCAN_ENTRY;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : mux8to1_scan_ctrl
`default_nettype wire

// File: tb/tb_mux8to1_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_mux8to1_scan_ctrl                                        |
// | Desc   : Directed bench for the scan controller around mux8to1.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_mux8to1_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cap_ready;
    logic       start, start0;
    logic [7:0] data_in, data_in0;
    logic       mux_out, mux_out0;
    logic [2:0] select, select0;
    logic       busy, busy0;
    logic       cap_valid, cap_valid0;
    logic [7:0] capture, capture0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux8to1 #(.SEL_WIDTH(3)) u_mux (
        .data_in (data_in), .select (select), .data_out (mux_out)
    );

    mux8to1_scan_ctrl #(.SEL_WIDTH(3), .SETTLE_CYCLES(1)) dut (
        .clk (clk), .rst (rst), .start (start), .mux_out (mux_out),
        .select (select), .busy (busy), .cap_valid (cap_valid),
        .cap_ready (cap_ready), .capture (capture)
    );

    mux8to1 #(.SEL_WIDTH(3)) u_mux0 (
        .data_in (data_in0), .select (select0), .data_out (mux_out0)
    );

    mux8to1_scan_ctrl #(.SEL_WIDTH(3), .SETTLE_CYCLES(0)) dut0 (
        .clk (clk), .rst (rst), .start (start0), .mux_out (mux_out0),
        .select (select0), .busy (busy0), .cap_valid (cap_valid0),
        .cap_ready (cap_ready), .capture (capture0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " select"},    32'(select),    32'd0);
        check({tag, " capture"},   32'(capture),   32'd0);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " cap_valid"}, 32'(cap_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start0 = 1'b0; cap_ready = 1'b0;
        data_in = 8'hAA; data_in0 = 8'h00;
        tick(2);
        rst = 1'b0;
        check_reset_values("init");

        // Basic scan with downstream always ready
        cap_ready = 1'b1;
        start = 1'b1; tick(1); start = 1'b0;
        for (int m = 0; m < 16; m++) begin
            check($sformatf("scan sel m%0d", m), 32'(select), 32'(m / 2));
            check($sformatf("scan busy m%0d", m), 32'(busy), 32'd1);
            check($sformatf("scan valid m%0d", m), 32'(cap_valid), 32'd0);
            tick(1);
        end
        check("scan valid",   32'(cap_valid), 32'd1);
        check("scan capture", 32'(capture),   32'hAA);
        check("scan sel end", 32'(select),    32'd0);
        check("scan busy end",32'(busy),      32'd0);
        tick(1);
        check("scan valid drop", 32'(cap_valid), 32'd0);

        // Backpressure in HOLD while the mux inputs change
        cap_ready = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        tick(16);
        data_in = 8'h55;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp valid k%0d", k),   32'(cap_valid), 32'd1);
            check($sformatf("bp capture k%0d", k), 32'(capture),   32'hAA);
            tick(1);
        end

        // Handshake and new START on the same HOLD edge
        cap_ready = 1'b1; start = 1'b1;
        tick(1);
        start = 1'b0;
        check("b2b busy",    32'(busy),      32'd1);
        check("b2b select",  32'(select),    32'd0);
        check("b2b valid",   32'(cap_valid), 32'd0);
        check("b2b capture", 32'(capture),   32'hAA);
        tick(16);
        check("b2b valid2",   32'(cap_valid), 32'd1);
        check("b2b capture2", 32'(capture),   32'h55);
        tick(1);

        // START while busy is ignored
        data_in = 8'hC3;
        start = 1'b1; tick(1); start = 1'b0;
        tick(6);
        check("ign sel3", 32'(select), 32'd3);
        start = 1'b1; tick(1); start = 1'b0;
        check("ign sel3b", 32'(select), 32'd3);
        check("ign busy",  32'(busy),   32'd1);
        tick(8);
        check("ign valid early", 32'(cap_valid), 32'd0);
        tick(1);
        check("ign valid",   32'(cap_valid), 32'd1);
        check("ign capture", 32'(capture),   32'hC3);
        tick(1);

        // Reset in the middle of a scan, then a clean rescan
        data_in = 8'h0F;
        start = 1'b1; tick(1); start = 1'b0;
        tick(8);
        check("mid sel4", 32'(select), 32'd4);
        rst = 1'b1; tick(2); rst = 1'b0;
        check_reset_values("midrst");
        start = 1'b1; tick(1); start = 1'b0;
        tick(16);
        check("rescan valid",   32'(cap_valid), 32'd1);
        check("rescan capture", 32'(capture),   32'h0F);
        tick(1);

        // Zero settle: SELECT advances every cycle
        data_in0 = 8'h3C;
        start0 = 1'b1; tick(1); start0 = 1'b0;
        for (int m = 0; m < 8; m++) begin
            check($sformatf("s0 sel m%0d", m), 32'(select0), 32'(m));
            check($sformatf("s0 valid m%0d", m), 32'(cap_valid0), 32'd0);
            tick(1);
        end
        check("s0 valid",   32'(cap_valid0), 32'd1);
        check("s0 capture", 32'(capture0),   32'h3C);
        check("s0 busy",    32'(busy0),      32'd0);
        tick(1);
        check("s0 valid drop", 32'(cap_valid0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mux8to1_scan_ctrl
`default_nettype wire
